sisc_fetch: RTL

Instruction fetch stage for the SISC processor. Holds the program counter, issues read requests to instruction memory over a req/ack handshake, and latches the returned word into the instruction register that drives the `ir` input of the `sisc` datapath top. Branch redirects from the control unit reload the PC and squash any fetch in flight.

---
 rtl/sisc_pkg.sv | 15 +
 rtl/sisc_pc_reg.sv | 40 ++++
 rtl/sisc_fetch.sv | 93 +++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared types and constants for the SISC fetch stage
package sisc_pkg;

   localparam int ADDR_W_DEF = 16;

   // Instruction register contents after reset (NOP encoding).
   localparam logic [31:0] IR_NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/sisc_pc_reg.sv
// rtl/sisc_pc_reg.sv - program counter register with load and increment
module sisc_pc_reg
   import sisc_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_val_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   // Next PC: a load wins over an increment; increment wraps silently.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   // PC register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         pc_q <= RESET_VAL;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/sisc_fetch.sv
// rtl/sisc_fetch.sv - SISC instruction fetch stage: PC, imem handshake, IR
module sisc_fetch
   import sisc_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_f,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_data,
   output logic [31:0]       ir,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              br_take,
   input  logic [ADDR_W-1:0] br_addr,
   output logic [ADDR_W-1:0] pc
);

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [31:0]  ir_q;
   logic         ir_we;
   logic         pc_inc;

   // Next state and control strobes; a redirect overrides every other event
   // and forces a one-cycle IDLE so the request line drops before refetch.
   always_comb begin
      state_d = state_q;
      ir_we   = 1'b0;
      pc_inc  = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (imem_ack) begin
               ir_we   = 1'b1;
               pc_inc  = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ir_ready) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (br_take) begin
         state_d = ST_IDLE;
         ir_we   = 1'b0;
         pc_inc  = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Instruction register, written only by an accepted acknowledge.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         ir_q <= IR_NOP;
      end else if (ir_we) begin
         ir_q <= imem_data;
      end
   end

   sisc_pc_reg #(
      .ADDR_W    (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst_i      (rst_f),
      .load_i     (br_take),
      .load_val_i (br_addr),
      .inc_i      (pc_inc),
      .pc_o       (pc)
   );

   // Outputs decode from registers only.
   assign imem_req  = (state_q == ST_REQ);
   assign imem_addr = pc;
   assign ir        = ir_q;
   assign ir_valid  = (state_q == ST_HOLD);

endmodule
